// File: rtl/ddr2_req_queue.sv
// Host request queue in front of a DDR2 controller: DEPTH-entry FIFO feeding a one-outstanding issue FSM.
// Optional read/write completion counters are enabled with `define DDR2_REQ_QUEUE_STATS_EN.
module ddr2_req_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 26,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       h_valid,
    output logic                       h_ready,
    input  logic                       h_we,
    input  logic [ADDR_W-1:0]          h_addr,
    input  logic [DATA_W-1:0]          h_wdata,
    output logic                       h_rvalid,
    output logic [DATA_W-1:0]          h_rdata,
    output logic [ADDR_W-1:0]          c_addr,
    output logic [DATA_W-1:0]          c_data_in,
    output logic                       c_rd_req,
    output logic                       c_wr_req,
    input  logic                       c_rdy,
    input  logic [DATA_W-1:0]          c_data_out,
    output logic [$clog2(DEPTH):0]     q_level
`ifdef DDR2_REQ_QUEUE_STATS_EN
    ,
    output logic [15:0]                rd_count,
    output logic [15:0]                wr_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

    state_t                state, state_nxt;
    logic [ENT_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [LVL_W-1:0]      level_nxt;
    logic                  push, pop;
    logic                  issue_we_p1;
    logic                  rd_done, wr_done;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign push    = h_valid & h_ready;
    assign pop     = (state == S_IDLE) && (q_level != '0);
    assign rd_done = (state == S_BUSY) && c_rdy && !issue_we_p1;
    assign wr_done = (state == S_BUSY) && c_rdy && issue_we_p1;

    always_comb begin
        level_nxt = q_level;
        if (push && !pop)
            level_nxt = q_level + LVL_W'(1);
        else if (pop && !push)
            level_nxt = q_level - LVL_W'(1);
    end

    // ---- stage p0: FIFO storage and occupancy ----
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {h_we, h_addr, h_wdata};
    end

    // h_ready comes from the next occupancy so a full queue stalls without a pop-to-ready path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_level <= '0;
            h_ready <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            q_level <= level_nxt;
            h_ready <= (level_nxt != LVL_W'(DEPTH));
        end
    end

    // ---- stage p1: issue registers held stable while the controller works ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_we_p1 <= 1'b0;
            c_addr      <= '0;
            c_data_in   <= '0;
        end else if (pop) begin
            {issue_we_p1, c_addr, c_data_in} <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (q_level != '0) state_nxt = S_BUSY;
            S_BUSY:  if (c_rdy)         state_nxt = S_GAP;
            S_GAP:                      state_nxt = S_IDLE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        c_rd_req = 1'b0;
        c_wr_req = 1'b0;
        if (state == S_BUSY) begin
            c_rd_req = !issue_we_p1;
            c_wr_req = issue_we_p1;
        end
    end

    // ---- stage p2: read return to the host ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_rvalid <= 1'b0;
            h_rdata  <= '0;
        end else begin
            h_rvalid <= rd_done;
            if (rd_done)
                h_rdata <= c_data_out;
        end
    end

`ifdef DDR2_REQ_QUEUE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_done)
                rd_count <= sat_inc(rd_count);
            if (wr_done)
                wr_count <= sat_inc(wr_count);
        end
    end
`endif

endmodule
